mult_sequencer: RTL and testbench

Sequential shift-and-add multiplier controller. It accepts one operand pair per transaction over a valid/ready handshake and iterates a single (N+1)-bit adder for N cycles. It then holds the 2N-bit product until the consumer takes it. The block replaces the fully unrolled N-stage adder chain wherever area matters more than throughput, and exposes the same product/sign outputs to downstream logic.

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_sequencer_if.sv | 40 ++++
 rtl/ripple_adder.sv | 22 ++
 rtl/mult_sequencer.sv | 144 ++++++++++++++
 tb/tb_mult_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types for the shift-and-add multiplier sequencer: FSM state encoding and
// iteration-counter sizing.
package mult_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StSign,
        StDone
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// Operand/result handshake bundle for mult_sequencer. The master side supplies operands
// and consumes the product; the slave side is the sequencer itself.
interface mult_sequencer_if #(
    parameter int unsigned N = 8
);
    logic           start_valid;
    logic           start_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           done_valid;
    logic           done_ready;
    logic [2*N-1:0] result;
    logic           result_negative;
    logic           busy;

    modport master (
        output start_valid,
        output a,
        output b,
        output done_ready,
        input  start_ready,
        input  done_valid,
        input  result,
        input  result_negative,
        input  busy
    );

    modport slave (
        input  start_valid,
        input  a,
        input  b,
        input  done_ready,
        output start_ready,
        output done_valid,
        output result,
        output result_negative,
        output busy
    );

endinterface

// File: rtl/ripple_adder.sv
// N-bit ripple-carry adder producing an (N+1)-bit sum; the carry out lands in the top bit.
module ripple_adder #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N:0]   sum
);

    // Carry held in a block-local variable so the chain is a single sequential walk.
    always_comb begin : p_ripple
        logic carry;
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        sum[N] = carry;
    end

endmodule

// File: rtl/mult_sequencer.sv
// Sequential shift-and-add multiplier: one (N+1)-bit add per cycle for N cycles, product held
// until taken. Define MULT_SIGNED_EN for two's-complement operands (adds a one-cycle SIGN step).
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input logic             clk,
    input logic             rst,
    mult_sequencer_if.slave bus
);

    localparam int unsigned CW = cnt_width(N);

    state_e         state_q, state_d;
    logic [N-1:0]   m_q, m_d;
    logic [N-1:0]   p_hi_q, p_hi_d;
    logic [N-1:0]   q_q, q_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [N-1:0]   addend;
    logic [N:0]     sum;
    logic [2*N-1:0] prod;
    logic [N-1:0]   a_mag;
    logic [N-1:0]   b_mag;

    assign prod   = {p_hi_q, q_q};
    assign addend = q_q[0] ? m_q : '0;

    ripple_adder #(
        .N (N)
    ) u_adder (
        .a   (p_hi_q),
        .b   (addend),
        .sum (sum)
    );

`ifdef MULT_SIGNED_EN
    logic           sign_q, sign_d;
    logic           neg_q, neg_d;
    logic           sign_in;
    logic [2*N-1:0] prod_neg;

    // |-2^(N-1)| wraps back to 2^(N-1), which is still correct read as unsigned.
    assign a_mag    = bus.a[N-1] ? (~bus.a + N'(1)) : bus.a;
    assign b_mag    = bus.b[N-1] ? (~bus.b + N'(1)) : bus.b;
    assign sign_in  = bus.a[N-1] ^ bus.b[N-1];
    assign prod_neg = ~prod + (2 * N)'(1);
`else
    assign a_mag = bus.a;
    assign b_mag = bus.b;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            m_q     <= '0;
            p_hi_q  <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
`ifdef MULT_SIGNED_EN
            sign_q  <= 1'b0;
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            p_hi_q  <= p_hi_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
`ifdef MULT_SIGNED_EN
            sign_q  <= sign_d;
            neg_q   <= neg_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        p_hi_d  = p_hi_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
`ifdef MULT_SIGNED_EN
        sign_d  = sign_q;
        neg_d   = neg_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start_valid) begin
                    m_d     = b_mag;
                    q_d     = a_mag;
                    p_hi_d  = '0;
                    cnt_d   = '0;
`ifdef MULT_SIGNED_EN
                    sign_d  = sign_in;
                    neg_d   = 1'b0;
`endif
                    state_d = StRun;
                end
            end
            StRun: begin
                // Carry out of the add becomes the new top bit of the running product.
                {p_hi_d, q_d} = {sum, q_q[N-1:1]};
                cnt_d         = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
`ifdef MULT_SIGNED_EN
                    state_d = StSign;
`else
                    state_d = StDone;
`endif
                end
            end
            StSign: begin
`ifdef MULT_SIGNED_EN
                if (sign_q && (prod != '0)) begin
                    {p_hi_d, q_d} = prod_neg;
                    neg_d         = 1'b1;
                end else begin
                    neg_d = 1'b0;
                end
`endif
                state_d = StDone;
            end
            StDone: begin
                if (bus.done_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.start_ready = (state_q == StIdle);
    assign bus.busy        = (state_q != StIdle);
    assign bus.done_valid  = (state_q == StDone);
    assign bus.result      = prod;
`ifdef MULT_SIGNED_EN
    assign bus.result_negative = neg_q;
`else
    assign bus.result_negative = 1'b0;
`endif

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer; expectations follow the build (MULT_SIGNED_EN or not).
module tb_mult_sequencer;

    localparam int unsigned N = 8;
`ifdef MULT_SIGNED_EN
    localparam int          LAT     = N + 1;
    localparam logic [15:0] R_FD_7  = 16'hFFEB;
    localparam logic        NEG_FD7 = 1'b1;
`else
    localparam int          LAT     = N;
    localparam logic [15:0] R_FD_7  = 16'h06EB;
    localparam logic        NEG_FD7 = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mult_sequencer_if #(.N(N)) bus ();

    mult_sequencer #(
        .N (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic wait_done(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.done_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_mult(input string name, input logic [N-1:0] av, input logic [N-1:0] bv,
                           input logic [2*N-1:0] exp_r, input logic exp_n);
        int cyc;
        bit ok;
        @(negedge clk);
        bus.a           = av;
        bus.b           = bv;
        bus.start_valid = 1'b1;
        n_cmp++;
        if (bus.start_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s start_ready: got %b want 1", name, bus.start_ready);
        end
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        wait_done(cyc, ok);
        n_cmp++;
        if (!ok || cyc != LAT) begin
            n_bad++;
            $display("FAIL %s latency: got %0d (seen=%0b) want %0d", name, cyc, ok, LAT);
        end
        n_cmp++;
        if (bus.result !== exp_r) begin
            n_bad++;
            $display("FAIL %s result: got %h want %h", name, bus.result, exp_r);
        end
        n_cmp++;
        if (bus.result_negative !== exp_n) begin
            n_bad++;
            $display("FAIL %s result_negative: got %b want %b", name, bus.result_negative, exp_n);
        end
        bus.done_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.done_ready = 1'b0;
        n_cmp++;
        if (bus.start_ready !== 1'b1 || bus.done_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s return_idle: got ready=%b valid=%b want ready=1 valid=0", name,
                     bus.start_ready, bus.done_valid);
        end
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus.start_valid = 1'b0;
        bus.done_ready  = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.start_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset start_ready: got %b want 1", bus.start_ready);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL reset busy: got %b want 0", bus.busy);
        end
        n_cmp++;
        if (bus.done_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset done_valid: got %b want 0", bus.done_valid);
        end
        n_cmp++;
        if (bus.result !== 16'h0000) begin
            n_bad++; $display("FAIL reset result: got %h want 0000", bus.result);
        end
        n_cmp++;
        if (bus.result_negative !== 1'b0) begin
            n_bad++; $display("FAIL reset result_negative: got %b want 0", bus.result_negative);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_products();
        do_mult("mul_13x11", 8'd13, 8'd11, 16'd143, 1'b0);
        do_mult("mul_FDx7", 8'hFD, 8'd7, R_FD_7, NEG_FD7);
        do_mult("mul_80x80", 8'h80, 8'h80, 16'h4000, 1'b0);
        do_mult("mul_0xFB", 8'h00, 8'hFB, 16'h0000, 1'b0);
    endtask

    task automatic test_backpressure();
        int  cyc;
        bit  ok;
        bit  stable;
        do_mult("bp_warmup", 8'd2, 8'd2, 16'd4, 1'b0);
        @(negedge clk);
        bus.a           = 8'd3;
        bus.b           = 8'd4;
        bus.start_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.a = 8'd9;
        bus.b = 8'd10;
        wait_done(cyc, ok);
        n_cmp++;
        if (!ok || cyc != LAT) begin
            n_bad++; $display("FAIL bp latency: got %0d (seen=%0b) want %0d", cyc, ok, LAT);
        end
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.result !== 16'd12 || bus.start_ready !== 1'b0 || bus.done_valid !== 1'b1)
                stable = 1'b0;
        end
        n_cmp++;
        if (!stable) begin
            n_bad++;
            $display("FAIL bp hold: got result=%h ready=%b valid=%b want 000c/0/1",
                     bus.result, bus.start_ready, bus.done_valid);
        end
        @(negedge clk);
        bus.done_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.start_ready !== 1'b1 || bus.done_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp release: got ready=%b valid=%b want 1/0",
                     bus.start_ready, bus.done_valid);
        end
        bus.done_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++; $display("FAIL bp pending_accept busy: got %b want 1", bus.busy);
        end
        wait_done(cyc, ok);
        n_cmp++;
        if (!ok || bus.result !== 16'd90) begin
            n_bad++; $display("FAIL bp pending_result: got %h (seen=%0b) want 005a", bus.result, ok);
        end
        bus.done_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.done_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        @(negedge clk);
        bus.a           = 8'd13;
        bus.b           = 8'd11;
        bus.start_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done_valid !== 1'b0 ||
            bus.result !== 16'h0000 || bus.result_negative !== 1'b0) begin
            n_bad++;
            $display("FAIL midrun reset outputs: got ready=%b busy=%b valid=%b res=%h neg=%b want 1/0/0/0000/0",
                     bus.start_ready, bus.busy, bus.done_valid, bus.result, bus.result_negative);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (LAT + 4) begin
            @(posedge clk);
            #1;
            if (bus.done_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++; $display("FAIL midrun no_done: got done_valid=1 want 0");
        end
        do_mult("mul_5x6", 8'd5, 8'd6, 16'd30, 1'b0);
    endtask

    initial begin
        test_reset();
        test_products();
        test_backpressure();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
